// File: rtl/aio_crc_comp_if.sv
// Handshake and config-RAM read bundle between the AIO init sequencer,
// the CRC compare responder and the config RAM read port.
interface aio_crc_comp_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 10
);
  logic              comp_crc_en;
  logic              comp_crc_done;
  logic              comp_crc_error;
  logic              ram_rd_en;
  logic [ADDR_W-1:0] ram_rd_addr;
  logic [DATA_W-1:0] ram_rd_data;
  logic [15:0]       crc_calc;
  logic              crc_busy;

  // Responder side
  modport slave (
    input  comp_crc_en,
    input  ram_rd_data,
    output comp_crc_done,
    output comp_crc_error,
    output ram_rd_en,
    output ram_rd_addr,
    output crc_calc,
    output crc_busy
  );

  // Sequencer / RAM side
  modport master (
    output comp_crc_en,
    output ram_rd_data,
    input  comp_crc_done,
    input  comp_crc_error,
    input  ram_rd_en,
    input  ram_rd_addr,
    input  crc_calc,
    input  crc_busy
  );
endinterface

// File: rtl/aio_crc_comp.sv
// CRC-16-CCITT compare responder: streams WORD_CNT image words plus the
// stored CRC word out of config RAM, folds the image into the CRC and
// returns a single done (match) or error (mismatch) pulse.
module aio_crc_comp #(
  parameter int          DATA_W    = 16,
  parameter int          ADDR_W    = 10,
  parameter int          BASE_ADDR = 0,
  parameter int          WORD_CNT  = 512,
  parameter int          RD_LAT    = 2,
  parameter logic [15:0] CRC_INIT  = 16'hFFFF
) (
  input  logic          sys_clk,
  input  logic          glbl_rst_n,
  aio_crc_comp_if.slave bus
);

  // Counters fit in ADDR_W bits because WORD_CNT <= 2^ADDR_W-1-BASE_ADDR.
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(WORD_CNT);
  localparam logic [ADDR_W-1:0] BASE_A   = ADDR_W'(BASE_ADDR);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    CHECK = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] issue_cnt_q, issue_cnt_d;
  logic [ADDR_W-1:0] ret_cnt_q;
  logic [RD_LAT-1:0] vld_q;
  logic [15:0]       crc_q;
  logic [15:0]       stored_q;
  logic [15:0]       crc_calc_q;
  logic              ret_valid;
  logic              start;
  logic              rd_en;
  logic              done;
  logic              err;

  // 16 (DATA_W) serial MSB-first CCITT steps unrolled into one word update.
  function automatic logic [15:0] crc_word(input logic [15:0] crc_in,
                                           input logic [DATA_W-1:0] d);
    logic [15:0] c;
    logic        fb;
    c = crc_in;
    for (int i = DATA_W - 1; i >= 0; i--) begin
      fb = c[15] ^ d[i];
      c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    end
    return c;
  endfunction

  // Head of the valid pipe marks a returning read word this cycle.
  assign ret_valid = vld_q[RD_LAT-1];

  // State register and read-issue counter.
  always_ff @(posedge sys_clk or negedge glbl_rst_n) begin
    if (!glbl_rst_n) begin
      state_q     <= IDLE;
      issue_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      issue_cnt_q <= issue_cnt_d;
    end
  end

  // Next-state and pulse decode; DRAIN leaves on the cycle the stored-CRC
  // word returns so the verdict lands one cycle later.
  always_comb begin
    state_d     = state_q;
    issue_cnt_d = issue_cnt_q;
    start       = 1'b0;
    rd_en       = 1'b0;
    done        = 1'b0;
    err         = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.comp_crc_en) begin
          start       = 1'b1;
          issue_cnt_d = '0;
          state_d     = READ;
        end
      end
      READ: begin
        rd_en       = 1'b1;
        issue_cnt_d = issue_cnt_q + 1'b1;
        if (issue_cnt_q == LAST_IDX) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (ret_valid && (ret_cnt_q == LAST_IDX)) begin
          state_d = CHECK;
        end
      end
      CHECK: begin
        done    = (crc_q == stored_q);
        err     = (crc_q != stored_q);
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Return tracking, CRC accumulation, stored-word capture and result latch.
  always_ff @(posedge sys_clk or negedge glbl_rst_n) begin
    if (!glbl_rst_n) begin
      vld_q      <= '0;
      ret_cnt_q  <= '0;
      crc_q      <= 16'h0000;
      stored_q   <= 16'h0000;
      crc_calc_q <= 16'h0000;
    end else begin
      vld_q[0] <= rd_en;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
      end
      if (start) begin
        crc_q     <= CRC_INIT;
        ret_cnt_q <= '0;
      end else if (ret_valid) begin
        ret_cnt_q <= ret_cnt_q + 1'b1;
        if (ret_cnt_q < LAST_IDX) begin
          crc_q <= crc_word(crc_q, bus.ram_rd_data);
        end else begin
          stored_q <= 16'(bus.ram_rd_data);
        end
      end
      // The last image word was folded one edge earlier, so crc_q is final.
      if ((state_q == DRAIN) && (state_d == CHECK)) begin
        crc_calc_q <= crc_q;
      end
    end
  end

  assign bus.ram_rd_en      = rd_en;
  assign bus.ram_rd_addr    = BASE_A + issue_cnt_q;
  assign bus.comp_crc_done  = done;
  assign bus.comp_crc_error = err;
  assign bus.crc_calc       = crc_calc_q;
  assign bus.crc_busy       = (state_q != IDLE);

endmodule

// File: tb/tb_aio_crc_comp.sv
// Scoreboard bench for aio_crc_comp: three instances (RD_LAT 2/1/4),
// expected verdicts queued at start and popped when a pulse appears.
module tb_aio_crc_comp;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  aio_crc_comp_if #(.DATA_W(16), .ADDR_W(4)) if_a ();
  aio_crc_comp_if #(.DATA_W(16), .ADDR_W(4)) if_b ();
  aio_crc_comp_if #(.DATA_W(16), .ADDR_W(4)) if_c ();

  aio_crc_comp #(.DATA_W(16), .ADDR_W(4), .BASE_ADDR(0), .WORD_CNT(4),
                 .RD_LAT(2), .CRC_INIT(16'h0000))
    dut_a (.sys_clk(clk), .glbl_rst_n(rst_n), .bus(if_a));
  aio_crc_comp #(.DATA_W(16), .ADDR_W(4), .BASE_ADDR(3), .WORD_CNT(8),
                 .RD_LAT(1), .CRC_INIT(16'hFFFF))
    dut_b (.sys_clk(clk), .glbl_rst_n(rst_n), .bus(if_b));
  aio_crc_comp #(.DATA_W(16), .ADDR_W(4), .BASE_ADDR(0), .WORD_CNT(8),
                 .RD_LAT(4), .CRC_INIT(16'hFFFF))
    dut_c (.sys_clk(clk), .glbl_rst_n(rst_n), .bus(if_c));

  // Observation vectors, index = instance
  logic [2:0]  done_v, err_v, rden_v, busy_v;
  logic [3:0]  addr_v [3];
  logic [15:0] calc_v [3];
  assign done_v = {if_c.comp_crc_done,  if_b.comp_crc_done,  if_a.comp_crc_done};
  assign err_v  = {if_c.comp_crc_error, if_b.comp_crc_error, if_a.comp_crc_error};
  assign rden_v = {if_c.ram_rd_en,      if_b.ram_rd_en,      if_a.ram_rd_en};
  assign busy_v = {if_c.crc_busy,       if_b.crc_busy,       if_a.crc_busy};
  assign addr_v[0] = if_a.ram_rd_addr;
  assign addr_v[1] = if_b.ram_rd_addr;
  assign addr_v[2] = if_c.ram_rd_addr;
  assign calc_v[0] = if_a.crc_calc;
  assign calc_v[1] = if_b.crc_calc;
  assign calc_v[2] = if_c.crc_calc;

  // Config RAM models with per-instance read latency
  logic [15:0] mem [3][16];
  logic [15:0] pa [2];
  logic [15:0] pb [1];
  logic [15:0] pc [4];
  always @(posedge clk) begin
    pa[0] <= mem[0][addr_v[0]];
    pa[1] <= pa[0];
    pb[0] <= mem[1][addr_v[1]];
    pc[0] <= mem[2][addr_v[2]];
    for (int i = 1; i < 4; i++) pc[i] <= pc[i-1];
  end
  assign if_a.ram_rd_data = pa[1];
  assign if_b.ram_rd_data = pb[0];
  assign if_c.ram_rd_data = pc[3];

  typedef struct {
    int          inst;
    int          cycle;
    bit          done;
    logic [15:0] crc;
  } exp_t;
  exp_t exp_q[$];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail = 0;
  int rd_idx = 0;
  int rd_start = 0;
  int rd_base = 0;
  int pulse_cnt = 0;
  int start_cyc = 0;

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int lat_of(input int k);
    return (k == 0) ? 2 : ((k == 1) ? 1 : 4);
  endfunction
  function automatic int wc_of(input int k);
    return (k == 0) ? 4 : 8;
  endfunction
  function automatic int base_of(input int k);
    return (k == 1) ? 3 : 0;
  endfunction

  // Reference CRC-16-CCITT over the image held in a RAM model
  function automatic logic [15:0] model_crc(input int k, input int base,
                                            input int n, input logic [15:0] seed);
    logic [15:0] c;
    logic [15:0] w;
    c = seed;
    for (int j = 0; j < n; j++) begin
      w = mem[k][base + j];
      for (int b = 15; b >= 0; b--) begin
        if (c[15] ^ w[b]) c = (c << 1) ^ 16'h1021;
        else              c = c << 1;
      end
    end
    return c;
  endfunction

  // Monitor: read address sequence and verdict pulses
  always @(negedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < 3; k++) begin
        if (rden_v[k]) begin
          check_val("rd_addr", 32'(addr_v[k]), 32'(rd_base + rd_idx - rd_start));
          rd_idx++;
        end
        if (done_v[k] || err_v[k]) begin
          exp_t e;
          pulse_cnt++;
          if (exp_q.size() == 0) begin
            check_val("unexpected_pulse", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            $display("txn inst=%0d cycle=%0d done=%0b error=%0b crc_calc=%04h",
                     k, cyc + 1 - start_cyc, done_v[k], err_v[k], calc_v[k]);
            check_val("pulse_inst", 32'(k), 32'(e.inst));
            check_val("pulse_cycle", 32'(cyc + 1), 32'(e.cycle));
            check_val("pulse_done", 32'(done_v[k]), 32'(e.done));
            check_val("pulse_error", 32'(err_v[k]), 32'(!e.done));
            check_val("crc_calc", 32'(calc_v[k]), 32'(e.crc));
          end
        end
      end
    end
  end

  task automatic set_en(input int k, input logic v);
    case (k)
      0: if_a.comp_crc_en = v;
      1: if_b.comp_crc_en = v;
      default: if_c.comp_crc_en = v;
    endcase
  endtask

  // Called at a negedge; start sampled at the next edge (cycle 0)
  task automatic start_run(input int k, input bit push, input bit exp_done,
                           input logic [15:0] exp_crc);
    start_cyc = cyc + 1;
    rd_start  = rd_idx;
    rd_base   = base_of(k);
    if (push) exp_q.push_back('{k, start_cyc + wc_of(k) + lat_of(k) + 2, exp_done, exp_crc});
    set_en(k, 1'b1);
    @(negedge clk);
    set_en(k, 1'b0);
    check_val("busy_rise", 32'(busy_v[k]), 32'd1);
  endtask

  task automatic wait_run(input int k);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy_v[k]) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_val("run_complete", 32'(exp_q.size() == 0 && !busy_v[k]), 32'd1);
    check_val("n_reads", 32'(rd_idx - rd_start), 32'(wc_of(k) + 1));
  endtask

  initial begin
    int s1;
    int p;
    logic [15:0] ref_crc;
    if_a.comp_crc_en = 1'b0;
    if_b.comp_crc_en = 1'b0;
    if_c.comp_crc_en = 1'b0;
    for (int k = 0; k < 3; k++)
      for (int a = 0; a < 16; a++) mem[k][a] = 16'h0000;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      check_val("rst_done", 32'(done_v[k]), 32'd0);
      check_val("rst_error", 32'(err_v[k]), 32'd0);
      check_val("rst_rd_en", 32'(rden_v[k]), 32'd0);
      check_val("rst_busy", 32'(busy_v[k]), 32'd0);
      check_val("rst_crc_calc", 32'(calc_v[k]), 32'd0);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // All-zero image, stored 0 -> done, crc 0
    start_run(0, 1'b1, 1'b1, 16'h0000);
    wait_run(0);
    // Single set LSB in last word -> crc 1021, stored matches
    mem[0][3] = 16'h0001;
    mem[0][4] = 16'h1021;
    start_run(0, 1'b1, 1'b1, 16'h1021);
    wait_run(0);
    // Same image, stored off by one bit -> error
    mem[0][4] = 16'h1020;
    start_run(0, 1'b1, 1'b0, 16'h1021);
    wait_run(0);

    // Asynchronous reset mid-run (between edges during cycle 4)
    start_run(0, 1'b0, 1'b0, 16'h0000);
    s1 = start_cyc;
    while (cyc != s1 + 3) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check_val("midrst_done", 32'(done_v[0]), 32'd0);
    check_val("midrst_error", 32'(err_v[0]), 32'd0);
    check_val("midrst_rd_en", 32'(rden_v[0]), 32'd0);
    check_val("midrst_busy", 32'(busy_v[0]), 32'd0);
    check_val("midrst_crc_calc", 32'(calc_v[0]), 32'd0);
    p = pulse_cnt;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    check_val("no_pulse_after_rst", 32'(pulse_cnt), 32'(p));

    // Zero image, stored 0001 -> error, crc 0
    mem[0][3] = 16'h0000;
    mem[0][4] = 16'h0001;
    start_run(0, 1'b1, 1'b0, 16'h0000);
    wait_run(0);

    // Start while busy is ignored; start as busy falls is accepted
    mem[0][4] = 16'h0000;
    start_run(0, 1'b1, 1'b1, 16'h0000);
    s1 = start_cyc;
    @(negedge clk);
    set_en(0, 1'b1);
    @(negedge clk);
    set_en(0, 1'b0);
    while (cyc != s1 + 8) @(negedge clk);
    check_val("busy_n_reads", 32'(rd_idx - rd_start), 32'd5);
    check_val("busy_one_pulse", 32'(exp_q.size()), 32'd0);
    check_val("busy_fall", 32'(busy_v[0]), 32'd0);
    start_run(0, 1'b1, 1'b1, 16'h0000);
    wait_run(0);

    // Latency sweep with random images against the reference model
    for (int k = 1; k < 3; k++) begin
      for (int rep = 0; rep < 4; rep++) begin
        for (int j = 0; j < 8; j++) mem[k][base_of(k) + j] = 16'($urandom);
        ref_crc = model_crc(k, base_of(k), 8, 16'hFFFF);
        if (rep[0] == 1'b0) mem[k][base_of(k) + 8] = ref_crc;
        else mem[k][base_of(k) + 8] = ref_crc ^ (16'h0001 << $urandom_range(0, 15));
        start_run(k, 1'b1, (rep[0] == 1'b0), ref_crc);
        wait_run(k);
      end
    end

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
